// File: rtl/ssd_scan_decoder_if.sv
// Scanned seven-segment bus plus the decoded frame it yields.
// The master side drives the display lines. The slave side is the decoder.
interface ssd_scan_decoder_if;
  logic [6:0] ssd_in;
  logic [3:0] ssd_ctl;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] blank;
  logic       frame_valid;
  logic       frame_err;

  modport master (
    output ssd_in, ssd_ctl,
    input  digit0, digit1, digit2, digit3, blank, frame_valid, frame_err
  );

  modport slave (
    input  ssd_in, ssd_ctl,
    output digit0, digit1, digit2, digit3, blank, frame_valid, frame_err
  );
endinterface

// File: rtl/ssd_scan_decoder.sv
// Samples a 4-digit scanned seven-segment bus and decodes it to BCD.
// The frame outputs update all together once every position has been captured.
module ssd_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  ssd_scan_decoder_if.slave bus
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  logic [10:0] cur, prev_q, prev_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic [3:0]  mask_q, mask_d;
  logic [3:0]  sh_dig_q [4];
  logic [3:0]  sh_dig_d [4];
  logic [3:0]  sh_blank_q, sh_blank_d;
  logic [3:0]  sh_ill_q, sh_ill_d;
  logic [3:0]  out_dig_q [4];
  logic [3:0]  out_dig_d [4];
  logic [3:0]  out_blank_q, out_blank_d;
  logic        out_err_q, out_err_d;
  logic        fv_q, fv_d;

  logic [3:0]  dec_val;
  logic        dec_blank, dec_ill;
  logic        ctl_valid;
  logic [1:0]  pos;
  logic        capture;

  assign cur = {bus.ssd_in, bus.ssd_ctl};

  always_comb begin
    dec_val   = 4'hE;
    dec_blank = 1'b0;
    dec_ill   = 1'b0;
    case (bus.ssd_in)
      7'b0000001: dec_val = 4'd0;
      7'b1001111: dec_val = 4'd1;
      7'b0010010: dec_val = 4'd2;
      7'b0000110: dec_val = 4'd3;
      7'b1001100: dec_val = 4'd4;
      7'b0100100: dec_val = 4'd5;
      7'b0100000: dec_val = 4'd6;
      7'b0001111: dec_val = 4'd7;
      7'b0000000: dec_val = 4'd8;
      7'b0000100: dec_val = 4'd9;
      7'b1111111: begin
        dec_val   = 4'hF;
        dec_blank = 1'b1;
      end
      default:    dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    ctl_valid = 1'b1;
    pos       = 2'd0;
    case (bus.ssd_ctl)
      4'b1110: pos = 2'd0;
      4'b1101: pos = 2'd1;
      4'b1011: pos = 2'd2;
      4'b0111: pos = 2'd3;
      default: ctl_valid = 1'b0;
    endcase
  end

  always_comb begin
    prev_d      = prev_q;
    cnt_d       = cnt_q;
    armed_d     = armed_q;
    mask_d      = mask_q;
    sh_dig_d    = sh_dig_q;
    sh_blank_d  = sh_blank_q;
    sh_ill_d    = sh_ill_q;
    out_dig_d   = out_dig_q;
    out_blank_d = out_blank_q;
    out_err_d   = out_err_q;
    fv_d        = 1'b0;
    capture     = 1'b0;

    if (cur != prev_q) begin
      prev_d  = cur;
      cnt_d   = '0;
      armed_d = 1'b1;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d   = cnt_q + 8'd1;
      capture = armed_q && ctl_valid && (cnt_d == CNT_MAX);
    end

    // The frame is loaded from the shadow values with this capture already
    // merged in, so the digit that completes the frame is not one edge stale.
    if (capture) begin
      armed_d         = 1'b0;
      sh_dig_d[pos]   = dec_val;
      sh_blank_d[pos] = dec_blank;
      sh_ill_d[pos]   = dec_ill;
      mask_d          = mask_q | (4'b0001 << pos);
      if (mask_d == '1) begin
        out_dig_d   = sh_dig_d;
        out_blank_d = sh_blank_d;
        out_err_d   = |sh_ill_d;
        fv_d        = 1'b1;
        mask_d      = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q      <= {7'h7F, 4'hF};
      cnt_q       <= '0;
      armed_q     <= 1'b1;
      mask_q      <= '0;
      sh_blank_q  <= '1;
      sh_ill_q    <= '0;
      out_blank_q <= '1;
      out_err_q   <= 1'b0;
      fv_q        <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        sh_dig_q[i]  <= 4'hF;
        out_dig_q[i] <= 4'hF;
      end
    end else begin
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      mask_q      <= mask_d;
      sh_dig_q    <= sh_dig_d;
      sh_blank_q  <= sh_blank_d;
      sh_ill_q    <= sh_ill_d;
      out_dig_q   <= out_dig_d;
      out_blank_q <= out_blank_d;
      out_err_q   <= out_err_d;
      fv_q        <= fv_d;
    end
  end

  assign bus.digit0      = out_dig_q[0];
  assign bus.digit1      = out_dig_q[1];
  assign bus.digit2      = out_dig_q[2];
  assign bus.digit3      = out_dig_q[3];
  assign bus.blank       = out_blank_q;
  assign bus.frame_err   = out_err_q;
  assign bus.frame_valid = fv_q;

endmodule
